// File: rtl/fml_vtx_capture.sv
// Trace-capture front end: watches the coprocessor issue/response handshakes and
// emits one vtx_valid transaction per retired instruction with pre/post register images.
module fml_vtx_capture #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned CNT_W         = 32
) (
  input  logic              vtx_clk,
  input  logic              vtx_reset,
  input  logic              cop_insn_valid,
  input  logic              cop_insn_ready,
  input  logic [31:0]       cop_insn_enc,
  input  logic [31:0]       cop_insn_rs1,
  input  logic              cop_rsp_valid,
  input  logic              cop_rsp_ready,
  input  logic [2:0]        cop_rsp_result,
  input  logic [31:0]       cop_rsp_wdata,
  input  logic [4:0]        cop_rsp_waddr,
  input  logic              cop_rsp_wen,
  input  logic [511:0]      cop_cprs,
  output logic              vtx_valid,
  output logic [31:0]       vtx_instr_enc,
  output logic [31:0]       vtx_instr_rs1,
  output logic [2:0]        vtx_instr_result,
  output logic [31:0]       vtx_instr_wdata,
  output logic [4:0]        vtx_instr_waddr,
  output logic              vtx_instr_wen,
  output logic [511:0]      vtx_cprs_pre,
  output logic [511:0]      vtx_cprs_post,
  output logic              vtx_timeout,
  output logic              vtx_overlap,
  output logic [CNT_W-1:0]  vtx_retired
);

  localparam int unsigned WCNT_W = 16;
  localparam int unsigned SCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [SCNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic                valid_q, valid_d;
  logic [31:0]         enc_q, enc_d;
  logic [31:0]         rs1_q, rs1_d;
  logic [2:0]          result_q, result_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [4:0]          waddr_q, waddr_d;
  logic                wen_q, wen_d;
  logic [511:0]        pre_q, pre_d;
  logic [511:0]        post_q, post_d;
  logic                timeout_q, timeout_d;
  logic                overlap_q, overlap_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic issue_fire_c;
  logic rsp_fire_c;

  // Handshake fire detection (monitor only, never drives ready)
  always_comb begin
    issue_fire_c = cop_insn_valid & cop_insn_ready;
    rsp_fire_c   = cop_rsp_valid & cop_rsp_ready;
  end

  // Next-state and capture logic for the issue -> wait -> settle sequence
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    settle_cnt_d = settle_cnt_q;
    valid_d      = 1'b0;
    enc_d        = enc_q;
    rs1_d        = rs1_q;
    result_d     = result_q;
    wdata_d      = wdata_q;
    waddr_d      = waddr_q;
    wen_d        = wen_q;
    pre_d        = pre_q;
    post_d       = post_q;
    timeout_d    = timeout_q;
    overlap_d    = overlap_q;
    retired_d    = retired_q;

    case (state_q)
      ST_IDLE: begin
        if (issue_fire_c) begin
          enc_d      = cop_insn_enc;
          rs1_d      = cop_insn_rs1;
          pre_d      = cop_cprs;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        if (issue_fire_c) overlap_d = 1'b1;
        if (rsp_fire_c) begin
          result_d     = cop_rsp_result;
          wdata_d      = cop_rsp_wdata;
          waddr_d      = cop_rsp_waddr;
          wen_d        = cop_rsp_wen;
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
          // Response never arrived: abandon the instruction without emitting
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        settle_cnt_d = settle_cnt_q + SCNT_W'(1);
        if (issue_fire_c) overlap_d = 1'b1;
        if (settle_cnt_q == SCNT_W'(SETTLE_CYCLES - 1)) begin
          post_d    = cop_cprs;
          valid_d   = 1'b1;
          retired_d = retired_q + CNT_W'(1);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and capture registers; reset drops any in-flight transaction
  always_ff @(posedge vtx_clk) begin
    if (vtx_reset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      settle_cnt_q <= '0;
      valid_q      <= 1'b0;
      enc_q        <= '0;
      rs1_q        <= '0;
      result_q     <= '0;
      wdata_q      <= '0;
      waddr_q      <= '0;
      wen_q        <= 1'b0;
      pre_q        <= '0;
      post_q       <= '0;
      timeout_q    <= 1'b0;
      overlap_q    <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      valid_q      <= valid_d;
      enc_q        <= enc_d;
      rs1_q        <= rs1_d;
      result_q     <= result_d;
      wdata_q      <= wdata_d;
      waddr_q      <= waddr_d;
      wen_q        <= wen_d;
      pre_q        <= pre_d;
      post_q       <= post_d;
      timeout_q    <= timeout_d;
      overlap_q    <= overlap_d;
      retired_q    <= retired_d;
    end
  end

  assign vtx_valid        = valid_q;
  assign vtx_instr_enc    = enc_q;
  assign vtx_instr_rs1    = rs1_q;
  assign vtx_instr_result = result_q;
  assign vtx_instr_wdata  = wdata_q;
  assign vtx_instr_waddr  = waddr_q;
  assign vtx_instr_wen    = wen_q;
  assign vtx_cprs_pre     = pre_q;
  assign vtx_cprs_post    = post_q;
  assign vtx_timeout      = timeout_q;
  assign vtx_overlap      = overlap_q;
  assign vtx_retired      = retired_q;

endmodule

// File: tb/tb_fml_vtx_capture.sv
// Bench for fml_vtx_capture: three instances with different settle/timeout/counter
// widths share one stimulus stream and are compared against a transaction-level model.
module tb_fml_vtx_capture;

  logic          vtx_clk = 1'b0;
  logic          vtx_reset;
  logic          iv, ir, rv, rr, wen;
  logic [31:0]   enc, rs1, wdata;
  logic [2:0]    result;
  logic [4:0]    waddr;
  logic [511:0]  cprs;

  logic          o_valid [3];
  logic [31:0]   o_enc   [3];
  logic [31:0]   o_rs1   [3];
  logic [2:0]    o_res   [3];
  logic [31:0]   o_wd    [3];
  logic [4:0]    o_wa    [3];
  logic          o_we    [3];
  logic [511:0]  o_pre   [3];
  logic [511:0]  o_post  [3];
  logic          o_to    [3];
  logic          o_ov    [3];
  logic [31:0]   o_ret0, o_ret1;
  logic [2:0]    o_ret2;

  int n_tests = 0;
  int n_fail  = 0;
  int n_strobe [3] = '{0, 0, 0};
  logic [31:0] cyc = '0;

  always #5 vtx_clk = ~vtx_clk;

  fml_vtx_capture #(.SETTLE_CYCLES(1), .TIMEOUT(8), .CNT_W(32)) u_dut0 (
    .vtx_clk(vtx_clk), .vtx_reset(vtx_reset),
    .cop_insn_valid(iv), .cop_insn_ready(ir), .cop_insn_enc(enc), .cop_insn_rs1(rs1),
    .cop_rsp_valid(rv), .cop_rsp_ready(rr), .cop_rsp_result(result), .cop_rsp_wdata(wdata),
    .cop_rsp_waddr(waddr), .cop_rsp_wen(wen), .cop_cprs(cprs),
    .vtx_valid(o_valid[0]), .vtx_instr_enc(o_enc[0]), .vtx_instr_rs1(o_rs1[0]),
    .vtx_instr_result(o_res[0]), .vtx_instr_wdata(o_wd[0]), .vtx_instr_waddr(o_wa[0]),
    .vtx_instr_wen(o_we[0]), .vtx_cprs_pre(o_pre[0]), .vtx_cprs_post(o_post[0]),
    .vtx_timeout(o_to[0]), .vtx_overlap(o_ov[0]), .vtx_retired(o_ret0));

  fml_vtx_capture #(.SETTLE_CYCLES(3), .TIMEOUT(8), .CNT_W(32)) u_dut1 (
    .vtx_clk(vtx_clk), .vtx_reset(vtx_reset),
    .cop_insn_valid(iv), .cop_insn_ready(ir), .cop_insn_enc(enc), .cop_insn_rs1(rs1),
    .cop_rsp_valid(rv), .cop_rsp_ready(rr), .cop_rsp_result(result), .cop_rsp_wdata(wdata),
    .cop_rsp_waddr(waddr), .cop_rsp_wen(wen), .cop_cprs(cprs),
    .vtx_valid(o_valid[1]), .vtx_instr_enc(o_enc[1]), .vtx_instr_rs1(o_rs1[1]),
    .vtx_instr_result(o_res[1]), .vtx_instr_wdata(o_wd[1]), .vtx_instr_waddr(o_wa[1]),
    .vtx_instr_wen(o_we[1]), .vtx_cprs_pre(o_pre[1]), .vtx_cprs_post(o_post[1]),
    .vtx_timeout(o_to[1]), .vtx_overlap(o_ov[1]), .vtx_retired(o_ret1));

  fml_vtx_capture #(.SETTLE_CYCLES(2), .TIMEOUT(3), .CNT_W(3)) u_dut2 (
    .vtx_clk(vtx_clk), .vtx_reset(vtx_reset),
    .cop_insn_valid(iv), .cop_insn_ready(ir), .cop_insn_enc(enc), .cop_insn_rs1(rs1),
    .cop_rsp_valid(rv), .cop_rsp_ready(rr), .cop_rsp_result(result), .cop_rsp_wdata(wdata),
    .cop_rsp_waddr(waddr), .cop_rsp_wen(wen), .cop_cprs(cprs),
    .vtx_valid(o_valid[2]), .vtx_instr_enc(o_enc[2]), .vtx_instr_rs1(o_rs1[2]),
    .vtx_instr_result(o_res[2]), .vtx_instr_wdata(o_wd[2]), .vtx_instr_waddr(o_wa[2]),
    .vtx_instr_wen(o_we[2]), .vtx_cprs_pre(o_pre[2]), .vtx_cprs_post(o_post[2]),
    .vtx_timeout(o_to[2]), .vtx_overlap(o_ov[2]), .vtx_retired(o_ret2));

  // Per-instance configuration
  function automatic logic [31:0] p_settle(input int k);
    case (k) 0: return 32'd1; 1: return 32'd3; default: return 32'd2; endcase
  endfunction
  function automatic logic [31:0] p_tmo(input int k);
    case (k) 0: return 32'd8; 1: return 32'd8; default: return 32'd3; endcase
  endfunction
  function automatic logic [31:0] p_mask(input int k);
    case (k) 0: return 32'hFFFF_FFFF; 1: return 32'hFFFF_FFFF; default: return 32'h7; endcase
  endfunction
  function automatic logic [31:0] ret_of(input int k);
    case (k) 0: return o_ret0; 1: return o_ret1; default: return {29'd0, o_ret2}; endcase
  endfunction

  // Transaction-level model: one in-flight instruction tracked by the cycle numbers
  // of its issue and response; expected outputs are whatever it last emitted.
  typedef struct packed {
    logic          busy;
    logic          rsp_seen;
    logic [31:0]   t_iss;
    logic [31:0]   t_rsp;
    logic [31:0]   enc;
    logic [31:0]   rs1;
    logic [2:0]    result;
    logic [31:0]   wdata;
    logic [4:0]    waddr;
    logic          wen;
    logic [511:0]  pre;
    logic [511:0]  post;
    logic          valid;
    logic          timeout;
    logic          overlap;
    logic [31:0]   retired;
  } mdl_t;

  mdl_t m [3];

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic model_step(input int k);
    logic iss, rsp;
    iss = iv & ir;
    rsp = rv & rr;
    m[k].valid = 1'b0;
    if (vtx_reset) begin
      m[k] = '0;
    end else if (!m[k].busy) begin
      if (iss) begin
        m[k].busy = 1'b1; m[k].rsp_seen = 1'b0; m[k].t_iss = cyc;
        m[k].enc = enc; m[k].rs1 = rs1; m[k].pre = cprs;
      end
    end else if (!m[k].rsp_seen) begin
      if (iss) m[k].overlap = 1'b1;
      if (rsp) begin
        m[k].rsp_seen = 1'b1; m[k].t_rsp = cyc;
        m[k].result = result; m[k].wdata = wdata; m[k].waddr = waddr; m[k].wen = wen;
      end else if (cyc - m[k].t_iss == p_tmo(k)) begin
        m[k].timeout = 1'b1; m[k].busy = 1'b0;
      end
    end else begin
      if (iss) m[k].overlap = 1'b1;
      if (cyc - m[k].t_rsp == p_settle(k)) begin
        m[k].post = cprs; m[k].valid = 1'b1; m[k].busy = 1'b0;
        m[k].retired = (m[k].retired + 32'd1) & p_mask(k);
      end
    end
  endtask

  task automatic model_cmp(input int k);
    logic [139:0] got, exp;
    got = {o_valid[k], o_enc[k], o_rs1[k], o_res[k], o_wd[k], o_wa[k], o_we[k],
           o_to[k], o_ov[k], ret_of(k)};
    exp = {m[k].valid, m[k].enc, m[k].rs1, m[k].result, m[k].wdata, m[k].waddr, m[k].wen,
           m[k].timeout, m[k].overlap, m[k].retired};
    chk($sformatf("model_fields i%0d c%0d", k, cyc), 512'(got), 512'(exp));
    chk($sformatf("model_pre i%0d c%0d", k, cyc), o_pre[k], m[k].pre);
    chk($sformatf("model_post i%0d c%0d", k, cyc), o_post[k], m[k].post);
  endtask

  // Model advance on every edge, compare 1 time unit later
  always @(posedge vtx_clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
    cyc = cyc + 32'd1;
    #1;
    for (int k = 0; k < 3; k++) begin
      model_cmp(k);
      if (o_valid[k]) n_strobe[k]++;
    end
  end

  task automatic cycle();
    @(posedge vtx_clk);
    #2;
  endtask

  task automatic drive_idle();
    iv = 1'b0; ir = 1'b0; rv = 1'b0; rr = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm, input int k);
    chk({nm, "_fields"}, 512'({o_valid[k], o_enc[k], o_rs1[k], o_res[k], o_wd[k], o_wa[k],
                              o_we[k], o_to[k], o_ov[k], ret_of(k)}), '0);
    chk({nm, "_pre"}, o_pre[k], '0);
    chk({nm, "_post"}, o_post[k], '0);
  endtask

  typedef struct {
    logic        iss;
    logic [31:0] enc;
    logic [31:0] rs1;
    logic        rsp;
    logic [2:0]  res;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] reg3;
    logic        ev;
    logic [31:0] eret;
    logic [31:0] eenc;
    logic [31:0] ers1;
    logic [2:0]  eres;
    logic [31:0] ewd;
    logic [4:0]  ewa;
    logic        ewe;
    logic [31:0] epre3;
    logic [31:0] epost3;
  } vec_t;

  vec_t tv [11];

  initial begin
    int s0;
    logic [511:0] snap;

    // Order: iss enc rs1 rsp res wd wa we reg3 | ev eret eenc ers1 eres ewd ewa ewe epre3 epost3
    tv[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{1, 32'h0000_702B, 32'h1234, 0, 0, 0, 0, 0, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[5]  = '{0, 0, 0, 1, 3'd0, 32'hDEAD, 5'd7, 1, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hB,
               1, 32'd1, 32'h0000_702B, 32'h1234, 3'd0, 32'hDEAD, 5'd7, 1, 32'hA, 32'hB};
    tv[7]  = '{1, 32'h1111_702B, 32'h55, 0, 0, 0, 0, 0, 32'hB, 0, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[8]  = '{0, 0, 0, 1, 3'd3, 32'hBEEF, 5'd2, 0, 32'hB, 0, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hC,
               1, 32'd2, 32'h1111_702B, 32'h55, 3'd3, 32'hBEEF, 5'd2, 0, 32'hB, 32'hC};
    tv[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hC, 0, 32'd2, 0, 0, 0, 0, 0, 0, 0, 0};

    vtx_reset = 1'b1;
    drive_idle();
    enc = '0; rs1 = '0; result = '0; wdata = '0; waddr = '0; wen = 1'b0; cprs = '0;
    repeat (3) cycle();
    for (int k = 0; k < 3; k++) chk_all_zero($sformatf("reset_state_i%0d", k), k);
    vtx_reset = 1'b0;

    // Basic transaction followed by a back-to-back issue in the strobe cycle
    for (int i = 0; i < 11; i++) begin
      iv = tv[i].iss; ir = tv[i].iss; enc = tv[i].enc; rs1 = tv[i].rs1;
      rv = tv[i].rsp; rr = tv[i].rsp; result = tv[i].res; wdata = tv[i].wd;
      waddr = tv[i].wa; wen = tv[i].we;
      cprs = '0; cprs[3*32 +: 32] = tv[i].reg3;
      cycle();
      chk($sformatf("vec%0d_flags", i), 512'({o_valid[0], o_ov[0], o_to[0], o_ret0}),
          512'({tv[i].ev, 1'b0, 1'b0, tv[i].eret}));
      if (tv[i].ev) begin
        chk($sformatf("vec%0d_instr", i),
            512'({o_enc[0], o_rs1[0], o_res[0], o_wd[0], o_wa[0], o_we[0]}),
            512'({tv[i].eenc, tv[i].ers1, tv[i].eres, tv[i].ewd, tv[i].ewa, tv[i].ewe}));
        chk($sformatf("vec%0d_cprs", i), 512'({o_pre[0][3*32 +: 32], o_post[0][3*32 +: 32]}),
            512'({tv[i].epre3, tv[i].epost3}));
      end
    end
    drive_idle();

    // Overlap: second issue during WAIT is flagged and dropped
    s0 = n_strobe[0];
    iv = 1'b1; ir = 1'b1; enc = 32'hAAAA_0001; cycle();
    enc = 32'hBBBB_0002; cycle();
    chk("overlap_flag", 512'(o_ov[0]), 512'(1'b1));
    drive_idle(); rv = 1'b1; rr = 1'b1; cycle();
    drive_idle(); cycle();
    chk("overlap_strobe", 512'({o_valid[0], o_enc[0]}), 512'({1'b1, 32'hAAAA_0001}));
    repeat (3) cycle();
    chk("overlap_count", 512'(n_strobe[0] - s0), 512'(1));

    vtx_reset = 1'b1; cycle();
    for (int k = 0; k < 3; k++) chk_all_zero($sformatf("reset2_i%0d", k), k);
    vtx_reset = 1'b0;

    // Timeout after eight cycles without response, then a normal instruction
    s0 = n_strobe[0];
    iv = 1'b1; ir = 1'b1; enc = 32'hCCCC_0003; cycle();
    drive_idle();
    repeat (7) cycle();
    chk("timeout_early", 512'(o_to[0]), 512'(1'b0));
    cycle();
    chk("timeout_set", 512'(o_to[0]), 512'(1'b1));
    iv = 1'b1; ir = 1'b1; enc = 32'hDDDD_0004; cycle();
    drive_idle(); rv = 1'b1; rr = 1'b1; cycle();
    drive_idle(); cycle();
    chk("timeout_recover", 512'({o_valid[0], o_enc[0], o_to[0]}),
        512'({1'b1, 32'hDDDD_0004, 1'b1}));
    chk("timeout_count", 512'(n_strobe[0] - s0), 512'(1));

    // Reset in the SETTLE cycle drops the transaction
    s0 = n_strobe[0];
    iv = 1'b1; ir = 1'b1; enc = 32'hEEEE_0005; cycle();
    drive_idle(); rv = 1'b1; rr = 1'b1; cycle();
    drive_idle(); vtx_reset = 1'b1; cycle();
    chk_all_zero("reset_settle", 0);
    vtx_reset = 1'b0;
    repeat (3) cycle();
    chk("reset_settle_count", 512'(n_strobe[0] - s0), 512'(0));

    // Three settle cycles: post image is taken at the edge ending r+3
    iv = 1'b1; ir = 1'b1; enc = 32'hF0F0_0006;
    for (int r = 0; r < 16; r++) cprs[r*32 +: 32] = $urandom;
    cycle();
    drive_idle(); rv = 1'b1; rr = 1'b1; cprs[5*32 +: 32] = 32'h100; cycle();
    drive_idle(); cprs[5*32 +: 32] = 32'h101; cycle();
    cprs[5*32 +: 32] = 32'h102; cycle();
    chk("settle3_early", 512'(o_valid[1]), 512'(1'b0));
    cprs[5*32 +: 32] = 32'h103;
    snap = cprs;
    cycle();
    cprs[5*32 +: 32] = 32'h104;
    chk("settle3_strobe", 512'({o_valid[1], o_enc[1], o_post[1][5*32 +: 32]}),
        512'({1'b1, 32'hF0F0_0006, 32'h103}));
    chk("settle3_post", o_post[1], snap);
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      vtx_reset = ($urandom_range(299) == 0);
      iv = ($urandom_range(3) == 0); ir = $urandom_range(1) == 1;
      rv = $urandom_range(2) == 0;   rr = $urandom_range(1) == 1;
      enc = $urandom; rs1 = $urandom; wdata = $urandom;
      result = 3'($urandom); waddr = 5'($urandom); wen = 1'($urandom);
      for (int r = 0; r < 16; r++) cprs[r*32 +: 32] = $urandom;
      cycle();
    end
    vtx_reset = 1'b0;
    drive_idle();
    repeat (5) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fml_vtx_capture.md
Name: fml_vtx_capture

Overview:
- Trace-capture front end for the formal ISE checkers.
- Passively monitors the coprocessor instruction-issue and response handshakes and snapshots the 16x32 coprocessor register file before issue and after writeback.
- Emits one single-cycle vtx_valid transaction per retired instruction, carrying the vtx_instr_* fields plus pre/post register images.
- Instantiated beside the core in the formal top; its outputs fan out to every instruction checker module.

Parameters:
- SETTLE_CYCLES, 1, cycles waited after the response handshake before sampling post register state (1..15).
- TIMEOUT, 64, max cycles from issue to response before abort (2..65535).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- vtx_clk  in  1  clock; all logic on rising edge.
- vtx_reset  in  1  synchronous, active-high reset.
- cop_insn_valid  in  1  core presents instruction to coprocessor.
- cop_insn_ready  in  1  coprocessor accepts instruction.
- cop_insn_enc  in  32  instruction encoding.
- cop_insn_rs1  in  32  GPR rs1 value accompanying instruction.
- cop_rsp_valid  in  1  coprocessor presents result.
- cop_rsp_ready  in  1  core accepts result.
- cop_rsp_result  in  3  result/status code.
- cop_rsp_wdata  in  32  GPR writeback data.
- cop_rsp_waddr  in  5  GPR writeback address.
- cop_rsp_wen  in  1  GPR writeback enable.
- cop_cprs  in  512  live register file; register i at bits [32i+31:32i].
- vtx_valid  out  1  one-cycle transaction strobe.
- vtx_instr_enc / vtx_instr_rs1  out  32/32  captured at issue.
- vtx_instr_result / vtx_instr_wdata / vtx_instr_waddr / vtx_instr_wen  out  3/32/5/1  captured at response.
- vtx_cprs_pre  out  512  register image at the issue edge.
- vtx_cprs_post  out  512  register image after settle.
- vtx_timeout  out  1  sticky: response not seen within TIMEOUT.
- vtx_overlap  out  1  sticky: issue seen while a transaction is in flight.
- vtx_retired  out  CNT_W  count of emitted transactions, wraps modulo 2^CNT_W.

Behaviour:
- Issue fire = cop_insn_valid & cop_insn_ready. Response fire = cop_rsp_valid & cop_rsp_ready. Block never drives ready.
- Reset (sync, high): all outputs 0, state IDLE, counters 0. Reset overrides every other event in the same cycle, including mid-transaction; a pending transaction is dropped without emitting.
- IDLE:
  - On issue fire: latch enc, rs1, cop_cprs into vtx_cprs_pre; clear wait counter; go WAIT.
  - Response fire in IDLE is ignored.
- WAIT:
  - Wait counter increments each cycle.
  - On response fire: latch result, wdata, waddr, wen; clear settle counter; go SETTLE.
  - If no response and counter reaches TIMEOUT-1: set vtx_timeout, go IDLE, no emit.
  - Issue fire in WAIT, including the same cycle as the response: set vtx_overlap, instruction ignored; the response still completes the current transaction.
- SETTLE:
  - Settle counter increments.
  - At the edge ending the SETTLE_CYCLES-th SETTLE cycle: latch cop_cprs into vtx_cprs_post, assert vtx_valid next cycle, increment vtx_retired, go IDLE.
  - Issue fire in SETTLE sets vtx_overlap and is ignored.
- vtx_valid:
  - High exactly one cycle per transaction.
  - Latency: with response fire in cycle r, vtx_valid is high in cycle r+1+SETTLE_CYCLES.
- Issue fire in the cycle vtx_valid is high (state IDLE) is legal and starts the next transaction.
- All vtx_instr_* and cprs outputs hold their last captured value between strobes. They are only meaningful while vtx_valid=1; checkers sample only then.
- Sticky flags clear only on reset.
- vtx_retired at max wraps to 0.

Test Plan:
- Basic: issue enc=0x0000_702B, rs1=0x1234 in cycle 2 with cop_cprs reg3=0xA; response cycle 5, result=0, wen=1, waddr=7, wdata=0xDEAD; reg3 becomes 0xB at edge ending cycle 5 -> vtx_valid high only in cycle 7; pre reg3=0xA, post reg3=0xB, fields match, vtx_retired=1.
- Same-cycle issue/response: back-to-back instructions with second issue in the vtx_valid cycle -> two strobes, vtx_overlap=0, vtx_retired=2.
- Overlap: second issue during WAIT -> vtx_overlap=1, exactly one strobe, captured enc from the first instruction.
- Timeout: issue with TIMEOUT=8 and no response -> vtx_timeout=1 eight cycles after issue, no strobe, state returns to IDLE, and a following instruction emits normally.
- Reset mid-SETTLE: assert vtx_reset in the SETTLE cycle -> no strobe; all outputs 0 the following cycle.
- SETTLE_CYCLES=3: response in cycle 10 -> vtx_valid in cycle 14; post image equals cop_cprs as sampled at the edge ending cycle 13.
